// File: rtl/axi_router_pkg.sv
// Shared types and constants for the AXI write-path router.
package axi_router_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StResp,
        StErrData,
        StErrResp
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int unsigned DEF_NUM_SLAVES  = 2;
    localparam int unsigned DEF_ID_W        = 8;
    localparam int unsigned DEF_ADDR_W      = 32;
    localparam int unsigned DEF_DATA_W      = 32;
    localparam int unsigned DEF_LEN_W       = 4;
    localparam int unsigned DEF_SIZE_W      = 3;
    localparam int unsigned DEF_REGION_BITS = 16;

endpackage

// File: rtl/awr_addr_decode.sv
// Address window decoder: slave index is the address above REGION_BITS; hit when it
// names an existing slave.
module awr_addr_decode
    import axi_router_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned REGION_BITS = DEF_REGION_BITS,
    localparam int unsigned IDX_W      = ADDR_W - REGION_BITS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              hit
);

    logic unused_offset;

    assign idx           = addr[ADDR_W-1:REGION_BITS];
    assign hit           = ({1'b0, idx} < (IDX_W + 1)'(NUM_SLAVES));
    assign unused_offset = ^addr[REGION_BITS-1:0];

endmodule

// File: rtl/axi_aw_router.sv
// One-outstanding AXI write router (AW/W/B) to NUM_SLAVES windowed slaves with a DECERR sink.
// Optional burst length checking with sticky LEN_ERR: define AXI_AW_ROUTER_LEN_CHECK_EN.
module axi_aw_router
    import axi_router_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = DEF_NUM_SLAVES,
    parameter int unsigned ID_W        = DEF_ID_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned LEN_W       = DEF_LEN_W,
    parameter int unsigned SIZE_W      = DEF_SIZE_W,
    parameter int unsigned REGION_BITS = DEF_REGION_BITS
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [ID_W-1:0]          AWID,
    input  logic [ADDR_W-1:0]        AWADDR,
    input  logic [LEN_W-1:0]         AWLEN,
    input  logic [SIZE_W-1:0]        AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [DATA_W/8-1:0]      WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [ID_W-1:0]          BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [ID_W-1:0]          AWID_S,
    output logic [ADDR_W-1:0]        AWADDR_S,
    output logic [LEN_W-1:0]         AWLEN_S,
    output logic [SIZE_W-1:0]        AWSIZE_S,
    output logic [1:0]               AWBURST_S,
    output logic [NUM_SLAVES-1:0]    AWVALID_S,
    input  logic [NUM_SLAVES-1:0]    AWREADY_S,
    output logic [DATA_W-1:0]        WDATA_S,
    output logic [DATA_W/8-1:0]      WSTRB_S,
    output logic                     WLAST_S,
    output logic [NUM_SLAVES-1:0]    WVALID_S,
    input  logic [NUM_SLAVES-1:0]    WREADY_S,
    input  logic [NUM_SLAVES*ID_W-1:0] BID_S,
    input  logic [NUM_SLAVES*2-1:0]  BRESP_S,
    input  logic [NUM_SLAVES-1:0]    BVALID_S,
    output logic [NUM_SLAVES-1:0]    BREADY_S
`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
    ,
    output logic                     LEN_ERR
`endif
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned IDX_W = ADDR_W - REGION_BITS;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_hit;
    logic             data_end;
    logic             err_end;

    awr_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .ADDR_W      (ADDR_W),
        .REGION_BITS (REGION_BITS)
    ) u_decode (
        .addr (AWADDR),
        .idx  (dec_idx),
        .hit  (dec_hit)
    );

    assign WDATA_S = WDATA;
    assign WSTRB_S = WSTRB;
    assign WLAST_S = WLAST;

`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
    logic [LEN_W-1:0] beat_q;
    logic             beat_last;
    logic             w_fire;

    assign beat_last = (beat_q == AWLEN_S);
    assign w_fire    = WVALID && WREADY;
    assign data_end  = WLAST || beat_last;
    // The sink has no slave to honour WLAST, so it trusts the programmed length.
    assign err_end   = beat_last;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            beat_q  <= '0;
            LEN_ERR <= 1'b0;
        end else begin
            if (state_q == StIdle) begin
                beat_q <= '0;
            end else if (w_fire) begin
                beat_q <= beat_q + 1'b1;
            end
            if (w_fire && (WLAST != beat_last)) begin
                LEN_ERR <= 1'b1;
            end
        end
    end
`else
    assign data_end = WLAST;
    assign err_end  = WLAST;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            AWID_S    <= '0;
            AWADDR_S  <= '0;
            AWLEN_S   <= '0;
            AWSIZE_S  <= '0;
            AWBURST_S <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && AWVALID) begin
                sel_q     <= dec_hit ? SEL_W'(dec_idx) : '0;
                AWID_S    <= AWID;
                AWADDR_S  <= AWADDR;
                AWLEN_S   <= AWLEN;
                AWSIZE_S  <= AWSIZE;
                AWBURST_S <= AWBURST;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BID       = '0;
        BRESP     = RESP_OKAY;
        AWVALID_S = '0;
        WVALID_S  = '0;
        BREADY_S  = '0;
        unique case (state_q)
            StIdle: begin
                AWREADY = 1'b1;
                if (AWVALID) begin
                    state_d = dec_hit ? StAddr : StErrData;
                end
            end
            StAddr: begin
                AWVALID_S[sel_q] = 1'b1;
                if (AWREADY_S[sel_q]) begin
                    state_d = StData;
                end
            end
            StData: begin
                WVALID_S[sel_q] = WVALID;
                WREADY          = WREADY_S[sel_q];
                if (WVALID && WREADY_S[sel_q] && data_end) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                BVALID          = BVALID_S[sel_q];
                BREADY_S[sel_q] = BREADY;
                BID             = BID_S[sel_q*ID_W +: ID_W];
                BRESP           = BRESP_S[sel_q*2 +: 2];
                if (BVALID_S[sel_q] && BREADY) begin
                    state_d = StIdle;
                end
            end
            StErrData: begin
                WREADY = 1'b1;
                if (WVALID && err_end) begin
                    state_d = StErrResp;
                end
            end
            StErrResp: begin
                BVALID = 1'b1;
                BRESP  = RESP_DECERR;
                BID    = AWID_S;
                if (BREADY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // Reset kills every handshake in the same cycle, not one edge later.
        if (ARESET) begin
            AWREADY   = 1'b0;
            WREADY    = 1'b0;
            BVALID    = 1'b0;
            BID       = '0;
            BRESP     = RESP_OKAY;
            AWVALID_S = '0;
            WVALID_S  = '0;
            BREADY_S  = '0;
        end
    end

endmodule

// File: tb/tb_axi_aw_router.sv
// Scoreboard bench for axi_aw_router: W beats and B responses are predicted at drive time.
module tb_axi_aw_router;
    import axi_router_pkg::*;

    localparam int NS     = 2;
    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int SIZE_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic ARESET;
    logic [ID_W-1:0] AWID;
    logic [ADDR_W-1:0] AWADDR;
    logic [LEN_W-1:0] AWLEN;
    logic [SIZE_W-1:0] AWSIZE;
    logic [1:0] AWBURST;
    logic AWVALID, AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic WLAST, WVALID, WREADY;
    logic [ID_W-1:0] BID;
    logic [1:0] BRESP;
    logic BVALID, BREADY;
    logic [ID_W-1:0] AWID_S;
    logic [ADDR_W-1:0] AWADDR_S;
    logic [LEN_W-1:0] AWLEN_S;
    logic [SIZE_W-1:0] AWSIZE_S;
    logic [1:0] AWBURST_S;
    logic [NS-1:0] AWVALID_S, AWREADY_S;
    logic [DATA_W-1:0] WDATA_S;
    logic [DATA_W/8-1:0] WSTRB_S;
    logic WLAST_S;
    logic [NS-1:0] WVALID_S, WREADY_S;
    logic [NS*ID_W-1:0] BID_S;
    logic [NS*2-1:0] BRESP_S;
    logic [NS-1:0] BVALID_S, BREADY_S;
`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
    logic LEN_ERR;
`endif

    axi_aw_router #(
        .NUM_SLAVES (NS), .ID_W (ID_W), .ADDR_W (ADDR_W), .DATA_W (DATA_W),
        .LEN_W (LEN_W), .SIZE_W (SIZE_W), .REGION_BITS (16)
    ) dut (
        .ACLK (clk), .ARESET (ARESET),
        .AWID (AWID), .AWADDR (AWADDR), .AWLEN (AWLEN), .AWSIZE (AWSIZE),
        .AWBURST (AWBURST), .AWVALID (AWVALID), .AWREADY (AWREADY),
        .WDATA (WDATA), .WSTRB (WSTRB), .WLAST (WLAST), .WVALID (WVALID), .WREADY (WREADY),
        .BID (BID), .BRESP (BRESP), .BVALID (BVALID), .BREADY (BREADY),
        .AWID_S (AWID_S), .AWADDR_S (AWADDR_S), .AWLEN_S (AWLEN_S), .AWSIZE_S (AWSIZE_S),
        .AWBURST_S (AWBURST_S), .AWVALID_S (AWVALID_S), .AWREADY_S (AWREADY_S),
        .WDATA_S (WDATA_S), .WSTRB_S (WSTRB_S), .WLAST_S (WLAST_S),
        .WVALID_S (WVALID_S), .WREADY_S (WREADY_S),
        .BID_S (BID_S), .BRESP_S (BRESP_S), .BVALID_S (BVALID_S), .BREADY_S (BREADY_S)
`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
        , .LEN_ERR (LEN_ERR)
`endif
    );

    typedef struct {int slave; logic [DATA_W-1:0] data; logic last;} wexp_t;
    typedef struct {logic [ID_W-1:0] id; logic [1:0] resp;} bexp_t;

    wexp_t wq[$];
    bexp_t bq[$];
    int checks   = 0;
    int failures = 0;

    // W scoreboard: slave index NS stands for the internal DECERR sink.
    always @(negedge clk) begin
        if (!ARESET && WVALID && WREADY) begin
            int obs;
            logic [DATA_W-1:0] d;
            logic l;
            wexp_t e;
            obs = NS;
            for (int i = 0; i < NS; i++) if (WVALID_S[i] && WREADY_S[i]) obs = i;
            d = (obs < NS) ? WDATA_S : WDATA;
            l = (obs < NS) ? WLAST_S : WLAST;
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL w_beat unexpected: slave=%0d data=%h", obs, d);
            end else begin
                e = wq.pop_front();
                if (obs !== e.slave || d !== e.data || l !== e.last) begin
                    failures++;
                    $display("FAIL w_beat: got slave=%0d data=%h last=%b, want slave=%0d data=%h last=%b",
                             obs, d, l, e.slave, e.data, e.last);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!ARESET && BVALID && BREADY) begin
            bexp_t e;
            checks++;
            if (bq.size() == 0) begin
                failures++;
                $display("FAIL b_resp unexpected: id=%h resp=%b", BID, BRESP);
            end else begin
                e = bq.pop_front();
                if (BID !== e.id || BRESP !== e.resp) begin
                    failures++;
                    $display("FAIL b_resp: got id=%h resp=%b, want id=%h resp=%b",
                             BID, BRESP, e.id, e.resp);
                end
            end
        end
    end

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len);
        int n;
        @(posedge clk); #1;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = 2'b01;
        n = 0;
        @(negedge clk);
        while (!AWREADY && n < 50) begin @(negedge clk); n++; end
        if (!AWREADY) begin
            checks++; failures++;
            $display("FAIL aw_timeout: AWREADY=%b want 1", AWREADY);
        end
        @(posedge clk); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_send(input int slave, input int nbeats, input int last_at,
                          input logic [DATA_W-1:0] base);
        int n;
        for (int k = 0; k < nbeats; k++) begin
            @(posedge clk); #1;
            WVALID = 1'b1; WDATA = base + DATA_W'(k); WSTRB = '1; WLAST = (k == last_at);
            wq.push_back('{slave, base + DATA_W'(k), (k == last_at)});
            n = 0;
            @(negedge clk);
            while (!WREADY && n < 50) begin @(negedge clk); n++; end
            if (!WREADY) begin
                checks++; failures++;
                $display("FAIL w_timeout: WREADY=%b want 1", WREADY);
            end
        end
        @(posedge clk); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic b_resp(input int slave, input logic [ID_W-1:0] id, input logic [1:0] resp,
                          input int hold);
        int n;
        logic [NS-1:0] exp_bready;
        exp_bready = '0;
        if (slave < NS) begin
            BVALID_S[slave] = 1'b1;
            BID_S[slave*ID_W +: ID_W] = id;
            BRESP_S[slave*2 +: 2] = resp;
            exp_bready[slave] = 1'b1;
        end
        bq.push_back('{id, resp});
        BREADY = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (BVALID !== 1'b1 || AWREADY !== 1'b0) begin
                failures++;
                $display("FAIL b_hold: BVALID=%b AWREADY=%b want 1/0", BVALID, AWREADY);
            end
        end
        if (hold > 0) begin @(posedge clk); #1; BREADY = 1'b1; end
        n = 0;
        @(negedge clk);
        while (!BVALID && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (BVALID !== 1'b1 || BREADY_S !== exp_bready) begin
            failures++;
            $display("FAIL b_route: BVALID=%b BREADY_S=%b want 1/%b", BVALID, BREADY_S, exp_bready);
        end
        @(posedge clk); #1;
        BREADY = 1'b0; BVALID_S = '0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL next_awready: AWREADY=%b want 1", AWREADY);
        end
    endtask

    task automatic test_reset;
        ARESET = 1'b1; WVALID = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({AWREADY, WREADY, BVALID, BID, BRESP} !== '0 ||
            {AWVALID_S, WVALID_S, BREADY_S} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: AWREADY=%b WREADY=%b BVALID=%b BID=%h BRESP=%b AWV_S=%b WV_S=%b BR_S=%b want all 0",
                     AWREADY, WREADY, BVALID, BID, BRESP, AWVALID_S, WVALID_S, BREADY_S);
        end
        checks++;
        if ({AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S} !== '0) begin
            failures++;
            $display("FAIL reset_aw_reg: AWADDR_S=%h AWID_S=%h want 0", AWADDR_S, AWID_S);
        end
        @(posedge clk); #1;
        ARESET = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: AWREADY=%b WREADY=%b want 1/0", AWREADY, WREADY);
        end
    endtask

    task automatic test_slave0;
        AWREADY_S = 2'b11; WREADY_S = 2'b11;
        aw_send(8'h05, 32'h0000_0010, 4'd0);
        @(negedge clk);
        checks++;
        if (AWVALID_S !== 2'b01 || AWADDR_S !== 32'h0000_0010 || AWID_S !== 8'h05 ||
            AWLEN_S !== 4'd0) begin
            failures++;
            $display("FAIL slave0_aw: AWVALID_S=%b AWADDR_S=%h AWID_S=%h want 01/00000010/05",
                     AWVALID_S, AWADDR_S, AWID_S);
        end
        w_send(0, 1, 0, 32'hA000_0000);
        b_resp(0, 8'h05, RESP_OKAY, 0);
    endtask

    task automatic test_delayed_awready;
        AWREADY_S = 2'b00;
        aw_send(8'h11, 32'h0001_FFFC, 4'd3);
        WVALID = 1'b1; WDATA = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin @(posedge clk); #1; AWREADY_S = 2'b11; end
            @(negedge clk);
            checks++;
            if (AWVALID_S !== 2'b10 || WREADY !== 1'b0 || WVALID_S !== 2'b00) begin
                failures++;
                $display("FAIL aw_hold%0d: AWVALID_S=%b WREADY=%b WVALID_S=%b want 10/0/00",
                         c, AWVALID_S, WREADY, WVALID_S);
            end
        end
        w_send(1, 4, 3, 32'hB000_0000);
        b_resp(1, 8'h11, RESP_SLVERR, 0);
    endtask

    task automatic test_decerr(input int hold);
        aw_send(8'h3A, 32'h0002_0000, 4'd1);
        @(negedge clk);
        checks++;
        if (AWVALID_S !== 2'b00 || WREADY !== 1'b1) begin
            failures++;
            $display("FAIL decerr_aw: AWVALID_S=%b WREADY=%b want 00/1", AWVALID_S, WREADY);
        end
        w_send(NS, 2, 1, 32'hC000_0000);
        b_resp(NS, 8'h3A, RESP_DECERR, hold);
    endtask

    task automatic test_bready_hold;
        aw_send(8'h07, 32'h0000_FFFC, 4'd0);
        w_send(0, 1, 0, 32'hD000_0000);
        b_resp(0, 8'h07, RESP_OKAY, 5);
        test_decerr(5);
    endtask

    task automatic test_reset_mid;
        AWREADY_S = 2'b11;
        aw_send(8'h22, 32'h0001_0020, 4'd3);
        w_send(1, 2, 99, 32'hE000_0000);
        ARESET = 1'b1; WVALID = 1'b1; WDATA = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (WREADY !== 1'b0 || WVALID_S !== 2'b00 || AWVALID_S !== 2'b00 ||
            AWREADY !== 1'b0 || BVALID !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: WREADY=%b WVALID_S=%b AWVALID_S=%b AWREADY=%b BVALID=%b want 0",
                     WREADY, WVALID_S, AWVALID_S, AWREADY, BVALID);
        end
        @(posedge clk); #1;
        ARESET = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        checks++;
        if (AWREADY !== 1'b1 || WREADY !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_idle: AWREADY=%b WREADY=%b want 1/0", AWREADY, WREADY);
        end
        aw_send(8'h23, 32'h0000_0040, 4'd0);
        w_send(0, 1, 0, 32'hF000_0000);
        b_resp(0, 8'h23, RESP_OKAY, 0);
    endtask

    task automatic test_short_burst;
`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
        checks++;
        if (LEN_ERR !== 1'b0) begin
            failures++;
            $display("FAIL len_err_pre: LEN_ERR=%b want 0", LEN_ERR);
        end
`endif
        aw_send(8'h44, 32'h0000_0100, 4'd3);
        w_send(0, 2, 1, 32'h5000_0000);
        b_resp(0, 8'h44, RESP_OKAY, 0);
`ifdef AXI_AW_ROUTER_LEN_CHECK_EN
        checks++;
        if (LEN_ERR !== 1'b1) begin
            failures++;
            $display("FAIL len_err_set: LEN_ERR=%b want 1", LEN_ERR);
        end
        @(posedge clk); #1; ARESET = 1'b1;
        @(posedge clk); #1; ARESET = 1'b0;
        @(negedge clk);
        checks++;
        if (LEN_ERR !== 1'b0) begin
            failures++;
            $display("FAIL len_err_clear: LEN_ERR=%b want 0", LEN_ERR);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        AWREADY_S = '0; WREADY_S = '0; BID_S = '0; BRESP_S = '0; BVALID_S = '0;
        test_reset();
        test_slave0();
        test_delayed_awready();
        test_decerr(0);
        test_bready_hold();
        test_reset_mid();
        test_short_burst();
        repeat (2) @(negedge clk);
        checks++;
        if (wq.size() != 0 || bq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: w left=%0d b left=%0d want 0/0", wq.size(), bq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
